// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
package fwd_pkg;
   localparam int REG_W = 5;
   localparam int CSR_W = 12;
   localparam logic [CSR_W-1:0] PROT0_DEF = 12'h305;
   localparam logic [CSR_W-1:0] PROT1_DEF = 12'h344;

   // One in-flight instruction past EX.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             regwrite;
      logic             is_load;
      logic             csr_valid;
      logic [CSR_W-1:0] csr_addr;
   } fwd_entry_t;
endpackage

// File: rtl/fwd_scoreboard_if.sv
// Pipeline <-> scoreboard bundle: EX/ID attributes in, forwarding selects and stall out.
interface fwd_scoreboard_if import fwd_pkg::*; #(
   parameter int NSRC  = 2,
   parameter int DEPTH = 2
);
   localparam int SW = $clog2(DEPTH + 1);

   logic                        ex_valid;
   logic                        ex_regwrite;
   logic                        ex_is_load;
   logic [REG_W-1:0]            ex_rd;
   logic                        ex_csr_valid;
   logic [CSR_W-1:0]            ex_csr_addr;
   logic [NSRC-1:0][REG_W-1:0]  ex_rs;
   logic [NSRC-1:0][REG_W-1:0]  id_rs;
   logic                        id_csr_valid;
   logic [CSR_W-1:0]            id_csr_addr;
   logic                        hold;
   logic                        flush;
   logic [NSRC-1:0][SW-1:0]     fwd_sel;
   logic [SW-1:0]               csr_fwd_sel;
   logic                        ld_stall;
   logic [31:0]                 stall_cycles;
   logic [31:0]                 fwd_events;

   modport master (
      output ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_csr_valid, ex_csr_addr,
             ex_rs, id_rs, id_csr_valid, id_csr_addr, hold, flush,
      input  fwd_sel, csr_fwd_sel, ld_stall, stall_cycles, fwd_events
   );

   modport slave (
      input  ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_csr_valid, ex_csr_addr,
             ex_rs, id_rs, id_csr_valid, id_csr_addr, hold, flush,
      output fwd_sel, csr_fwd_sel, ld_stall, stall_cycles, fwd_events
   );
endinterface

// File: rtl/fwd_scoreboard_match.sv
// Youngest-first priority search. Position k (0-based) reports k+1; a kill
// at a younger position than any hit forces the result to 0.
module fwd_match #(
   parameter int N  = 2,
   parameter int SW = $clog2(N + 1)
) (
   input  logic [N-1:0]  hit,
   input  logic [N-1:0]  kill,
   output logic [SW-1:0] sel
);
   // Scan oldest to youngest so the youngest candidate writes last and wins.
   always_comb begin
      sel = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (hit[k] | kill[k])
            sel = kill[k] ? '0 : SW'(k + 1);
      end
   end
endmodule

// File: rtl/fwd_scoreboard.sv
// Tracks in-flight producers after EX, selects GPR/CSR forwarding sources,
// requests load-use stalls and keeps saturating perf counters.
module fwd_scoreboard import fwd_pkg::*; #(
   parameter int               DEPTH    = 2,
   parameter int               NSRC     = 2,
   parameter int               LOAD_LAT = 1,
   parameter logic [CSR_W-1:0] PROT0    = PROT0_DEF,
   parameter logic [CSR_W-1:0] PROT1    = PROT1_DEF
) (
   input logic              clk,
   input logic              rst_n,
   fwd_scoreboard_if.slave  sb
);
   localparam int SW = $clog2(DEPTH + 1);
   localparam int CW = $clog2(LOAD_LAT + 1);

   fwd_entry_t                   ent [DEPTH];   // ent[0] is MEM, ent[DEPTH-1] is WB
   logic [NSRC-1:0][DEPTH-1:0]   rhit;
   logic [DEPTH-1:0]             c_ok;
   logic [DEPTH-1:0][CSR_W-1:0]  c_addr;
   logic [DEPTH-1:0]             chit, ckill;
   logic [NSRC-1:0][SW-1:0]      fwd_sel;
   logic [SW-1:0]                csr_sel;
   logic                         det, ld_stall;
   logic [CW-1:0]                stall_cnt;
   logic [31:0]                  stall_cycles, fwd_events;

   // Producer shift register; frozen (and flush ignored) under hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
      end else if (!sb.hold) begin
         ent[0] <= '{valid:     sb.ex_valid & ~sb.flush,
                     rd:        sb.ex_rd,
                     regwrite:  sb.ex_regwrite,
                     is_load:   sb.ex_is_load,
                     csr_valid: sb.ex_csr_valid,
                     csr_addr:  sb.ex_csr_addr};
         for (int k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
      end
   end

   // GPR match vectors per EX source; x0 never forwards.
   always_comb begin
      rhit = '0;
      for (int i = 0; i < NSRC; i++)
         for (int k = 0; k < DEPTH; k++)
            rhit[i][k] = ent[k].valid & ent[k].regwrite & (ent[k].rd != '0) &
                         (ent[k].rd == sb.ex_rs[i]);
   end

   // CSR candidates: EX first, then entries 1..DEPTH-1 (WB has already retired the write).
   always_comb begin
      c_ok      = '0;
      c_addr    = '0;
      c_ok[0]   = sb.ex_valid & sb.ex_csr_valid;
      c_addr[0] = sb.ex_csr_addr;
      for (int j = 1; j < DEPTH; j++) begin
         c_ok[j]   = ent[j-1].valid & ent[j-1].csr_valid;
         c_addr[j] = ent[j-1].csr_addr;
      end
   end

   // A protected producer still matches but kills the search, so no older copy leaks through.
   always_comb begin
      chit  = '0;
      ckill = '0;
      for (int j = 0; j < DEPTH; j++) begin
         if (sb.id_csr_valid && c_ok[j] && c_addr[j] == sb.id_csr_addr) begin
            if (c_addr[j] == PROT0 || c_addr[j] == PROT1) ckill[j] = 1'b1;
            else                                          chit[j]  = 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      fwd_match #(.N(DEPTH), .SW(SW)) u_match (
         .hit  (rhit[i]),
         .kill ({DEPTH{1'b0}}),
         .sel  (fwd_sel[i])
      );
   end

   fwd_match #(.N(DEPTH), .SW(SW)) u_csr_match (
      .hit  (chit),
      .kill (ckill),
      .sel  (csr_sel)
   );

   // Load-use detect: EX load whose rd feeds any ID source.
   always_comb begin
      det = 1'b0;
      for (int i = 0; i < NSRC; i++)
         if (sb.id_rs[i] == sb.ex_rd) det = 1'b1;
      det = det & sb.ex_valid & sb.ex_is_load & sb.ex_regwrite & (sb.ex_rd != '0);
   end

   assign ld_stall = det | (stall_cnt != '0);

   // Remaining stall cycles after the detect cycle; advances only while not held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  stall_cnt <= '0;
      else if (!sb.hold) begin
         if (stall_cnt != '0)      stall_cnt <= stall_cnt - 1'b1;
         else if (det)             stall_cnt <= CW'(LOAD_LAT - 1);
      end
   end

   // Saturating perf counters, counted only on advancing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         fwd_events   <= '0;
      end else if (!sb.hold) begin
         if (ld_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
         if ((|fwd_sel) && fwd_events != '1) fwd_events   <= fwd_events + 32'd1;
      end
   end

   assign sb.fwd_sel      = fwd_sel;
   assign sb.csr_fwd_sel  = csr_sel;
   assign sb.ld_stall     = ld_stall;
   assign sb.stall_cycles = stall_cycles;
   assign sb.fwd_events   = fwd_events;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_fwd_scoreboard;
   import fwd_pkg::*;

   localparam int DEPTH = 2, NSRC = 2, LOAD_LAT = 2;
   localparam int SW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [NSRC-1:0][SW-1:0] fwd;
      logic [SW-1:0]           csr;
      logic                    ld;
      logic [31:0]             sc;
      logic [31:0]             fe;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fwd_scoreboard_if #(.NSRC(NSRC), .DEPTH(DEPTH)) bus ();

   fwd_scoreboard #(.DEPTH(DEPTH), .NSRC(NSRC), .LOAD_LAT(LOAD_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (bus.slave)
   );

   int n_cmp = 0, n_bad = 0;
   exp_t exp_q[$];

   // Reference model: list of instructions that left EX (youngest first), stall cycles still owed, counts.
   fwd_entry_t hist[$];
   int         owed;
   longint     m_sc, m_fe;

   task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_cycle();
      exp_t e;
      int   f, pos;
      bit   det, anyf, found;
      logic v, cv;
      logic [11:0] a;
      fwd_entry_t r;
      if (!rst_n) begin
         hist.delete();
         repeat (DEPTH) hist.push_back('0);
         owed = 0; m_sc = 0; m_fe = 0;
      end
      anyf = 0;
      for (int i = 0; i < NSRC; i++) begin
         f = 0;
         for (int k = 0; k < DEPTH; k++)
            if (f == 0 && hist[k].valid && hist[k].regwrite && hist[k].rd != 0 &&
                hist[k].rd == bus.ex_rs[i]) f = k + 1;
         e.fwd[i] = SW'(f);
         if (f != 0) anyf = 1;
      end
      pos = 0; found = 0;
      if (bus.id_csr_valid) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (j == 0) begin v = bus.ex_valid; cv = bus.ex_csr_valid; a = bus.ex_csr_addr; end
            else begin v = hist[j-1].valid; cv = hist[j-1].csr_valid; a = hist[j-1].csr_addr; end
            if (!found && v && cv && a == bus.id_csr_addr) begin
               found = 1;
               pos = (a == 12'h305 || a == 12'h344) ? 0 : j + 1;
            end
         end
      end
      e.csr = SW'(pos);
      det = 0;
      for (int i = 0; i < NSRC; i++) if (bus.id_rs[i] == bus.ex_rd) det = 1;
      det = det && bus.ex_valid && bus.ex_is_load && bus.ex_regwrite && bus.ex_rd != 0;
      e.ld = det || owed > 0;
      e.sc = m_sc[31:0];
      e.fe = m_fe[31:0];
      exp_q.push_back(e);
      if (rst_n && !bus.hold) begin
         if (e.ld && m_sc < 64'hFFFF_FFFF) m_sc++;
         if (anyf && m_fe < 64'hFFFF_FFFF) m_fe++;
         if (owed > 0) owed--;
         else if (det) owed = LOAD_LAT - 1;
         r.valid = bus.ex_valid & ~bus.flush; r.rd = bus.ex_rd; r.regwrite = bus.ex_regwrite;
         r.is_load = bus.ex_is_load; r.csr_valid = bus.ex_csr_valid; r.csr_addr = bus.ex_csr_addr;
         hist.push_front(r);
         void'(hist.pop_back());
      end
   endtask

   // Inputs are set at posedge+1; one expectation per cycle, then advance.
   task automatic cycle();
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.ex_valid = 0; bus.ex_regwrite = 0; bus.ex_is_load = 0; bus.ex_rd = '0;
      bus.ex_csr_valid = 0; bus.ex_csr_addr = '0; bus.ex_rs = '0; bus.id_rs = '0;
      bus.id_csr_valid = 0; bus.id_csr_addr = '0; bus.hold = 0; bus.flush = 0;
   endtask

   task automatic set_ex(bit wr, bit ld, logic [4:0] rd);
      bus.ex_valid = 1; bus.ex_regwrite = wr; bus.ex_is_load = ld; bus.ex_rd = rd;
   endtask

   task automatic set_csr(logic [11:0] a);
      bus.ex_valid = 1; bus.ex_csr_valid = 1; bus.ex_csr_addr = a;
   endtask

   task automatic query(logic [11:0] a);
      bus.id_csr_valid = 1; bus.id_csr_addr = a;
   endtask

   // Monitor: every cycle the DUT presents a full output set.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cmp("sb_fwd_sel",      32'(bus.fwd_sel),     32'(e.fwd));
         cmp("sb_csr_fwd_sel",  32'(bus.csr_fwd_sel), 32'(e.csr));
         cmp("sb_ld_stall",     32'(bus.ld_stall),    32'(e.ld));
         cmp("sb_stall_cycles", bus.stall_cycles,     e.sc);
         cmp("sb_fwd_events",   bus.fwd_events,       e.fe);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      logic [11:0] csr_tab [4];
      csr_tab[0] = 12'h300; csr_tab[1] = 12'h305; csr_tab[2] = 12'h344; csr_tab[3] = 12'h301;
      idle();
      rst_n = 0;
      @(posedge clk); #1;
      #1 cmp("reset_fwd", 32'(bus.fwd_sel), 0);
      cmp("reset_sc", bus.stall_cycles, 0);
      cycle(); cycle();
      rst_n = 1;

      // Youngest of two producers wins; only-WB match; x0 never forwards.
      idle(); set_ex(1, 0, 5'd1); cycle();
      idle(); set_ex(1, 0, 5'd1); cycle();
      idle(); bus.ex_rs[0] = 5'd1;
      #1 cmp("s_mem_wins", 32'(bus.fwd_sel[0]), 1); cycle();
      idle(); bus.ex_rs[0] = 5'd1;
      #1 cmp("s_wb_only", 32'(bus.fwd_sel[0]), 2); cycle();
      idle(); set_ex(1, 0, 5'd0); cycle();
      idle(); bus.ex_rs[0] = 5'd0;
      #1 cmp("s_rd0", 32'(bus.fwd_sel[0]), 0); cycle();

      // Load-use: two stall cycles.
      idle(); set_ex(1, 1, 5'd5); bus.id_rs[1] = 5'd5;
      #1 cmp("s_ld_c0", 32'(bus.ld_stall), 1); cycle();
      idle();
      #1 cmp("s_ld_c1", 32'(bus.ld_stall), 1); cycle();
      idle();
      #1 cmp("s_ld_done", 32'(bus.ld_stall), 0);
      cmp("s_ld_count", bus.stall_cycles, 2); cycle();

      // Hold mid-stall freezes entries, stall and counters.
      idle(); set_ex(1, 1, 5'd5); bus.id_rs[1] = 5'd5; cycle();
      for (int h = 0; h < 3; h++) begin
         idle(); bus.hold = 1; bus.flush = 1; bus.ex_rs[0] = 5'd5;
         #1 cmp("s_hold_ld", 32'(bus.ld_stall), 1);
         cmp("s_hold_fwd", 32'(bus.fwd_sel[0]), 1);
         cmp("s_hold_sc", bus.stall_cycles, 3);
         cycle();
      end
      idle();
      #1 cmp("s_rel_ld", 32'(bus.ld_stall), 1); cycle();
      idle();
      #1 cmp("s_rel_end", 32'(bus.ld_stall), 0);
      cmp("s_rel_sc", bus.stall_cycles, 4); cycle();

      // CSR forwarding and protected addresses.
      idle(); set_csr(12'h300); query(12'h300);
      #1 cmp("s_csr_ex", 32'(bus.csr_fwd_sel), 1); cycle();
      idle(); set_csr(12'h305); cycle();
      idle(); set_csr(12'h305); query(12'h305);
      #1 cmp("s_csr_prot", 32'(bus.csr_fwd_sel), 0); cycle();
      idle(); set_csr(12'h300); query(12'h305);
      #1 cmp("s_csr_prot_e1", 32'(bus.csr_fwd_sel), 0); cycle();
      idle(); query(12'h300);
      #1 cmp("s_csr_e1", 32'(bus.csr_fwd_sel), 2); cycle();

      // Flushed producer never forwards; async reset clears mid-stall.
      idle(); set_ex(1, 0, 5'd3); bus.flush = 1; cycle();
      idle(); bus.ex_rs[0] = 5'd3;
      #1 cmp("s_flush", 32'(bus.fwd_sel[0]), 0); cycle();
      idle(); set_ex(1, 1, 5'd7); bus.id_rs[0] = 5'd7; cycle();
      idle(); rst_n = 0;
      #1 cmp("s_rst_ld", 32'(bus.ld_stall), 0);
      cmp("s_rst_sc", bus.stall_cycles, 0);
      cmp("s_rst_fe", bus.fwd_events, 0);
      cycle();
      rst_n = 1;

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         idle();
         bus.ex_valid     = ($urandom_range(0, 9) < 8);
         bus.ex_regwrite  = ($urandom_range(0, 9) < 7);
         bus.ex_is_load   = ($urandom_range(0, 9) < 3);
         bus.ex_rd        = 5'($urandom_range(0, 7));
         bus.ex_csr_valid = ($urandom_range(0, 9) < 4);
         bus.ex_csr_addr  = csr_tab[$urandom_range(0, 3)];
         for (int i = 0; i < NSRC; i++) begin
            bus.ex_rs[i] = 5'($urandom_range(0, 7));
            bus.id_rs[i] = 5'($urandom_range(0, 7));
         end
         bus.id_csr_valid = ($urandom_range(0, 9) < 6);
         bus.id_csr_addr  = csr_tab[$urandom_range(0, 3)];
         bus.hold         = ($urandom_range(0, 9) < 2);
         bus.flush        = ($urandom_range(0, 9) < 2);
         rst_n            = ($urandom_range(0, 99) != 0);
         cycle();
      end
      rst_n = 1; idle();
      @(negedge clk); #1;
      cmp("queue_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
